// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and types for the fetch stage
package mips_pkg;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_JR     = 2'b11;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HELD  = 2'd2
  } fetch_state_t;

  // Targets are word addresses: the two low bits are never honoured.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next-PC 4:1 selector
module pc_next_mux
  import mips_pkg::*;
(
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  // Pick the next PC; every non-sequential target is word aligned.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SRC_BRANCH: next_pc = align_word(branch_target);
      PC_SRC_JUMP:   next_pc = align_word(jump_target);
      PC_SRC_JR:     next_pc = align_word(jr_target);
      default:       next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  fetch_addr;
  logic [31:0]  held_word;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         transfer;
  logic         redirect;
  logic         capture;
  logic         bubble;
  logic [31:0]  capture_word;

  assign pc_plus4  = pc + 32'd4;
  assign imem_req  = rst_n && (state != ST_HELD);
  assign imem_addr = fetch_addr;
  assign transfer  = imem_req && imem_ready;
  assign redirect  = (pc_src != PC_SRC_SEQ) && !stall;

  pc_next_mux u_pc_next_mux (
    .pc_src        (pc_src),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .next_pc       (target)
  );

  // Fetch FSM: owns pc, fetch_addr and the word buffered across a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      held_word  <= NOP;
    end else begin
      case (state)
        ST_FETCH: begin
          if (redirect) begin
            pc <= target;
            if (transfer) fetch_addr <= target;
            else          state      <= ST_DRAIN;
          end else if (transfer) begin
            if (stall) begin
              held_word <= imem_rdata;
              state     <= ST_HELD;
            end else begin
              pc         <= pc_plus4;
              fetch_addr <= pc_plus4;
            end
          end
        end
        ST_DRAIN: begin
          if (redirect) pc <= target;
          if (transfer) begin
            fetch_addr <= redirect ? target : pc;
            state      <= ST_FETCH;
          end
        end
        ST_HELD: begin
          if (redirect) begin
            pc         <= target;
            fetch_addr <= target;
            state      <= ST_FETCH;
          end else if (!stall) begin
            pc         <= pc_plus4;
            fetch_addr <= pc_plus4;
            state      <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Decide whether IF/ID captures a word, takes a bubble, or holds.
  always_comb begin
    capture      = 1'b0;
    bubble       = 1'b0;
    capture_word = imem_rdata;
    case (state)
      ST_FETCH: begin
        if (redirect)                   bubble  = 1'b1;
        else if (transfer && !stall)    capture = 1'b1;
        else if (!transfer && !stall)   bubble  = 1'b1;
      end
      ST_DRAIN: bubble = !stall;
      ST_HELD: begin
        if (redirect) begin
          bubble = 1'b1;
        end else if (!stall) begin
          capture      = 1'b1;
          capture_word = held_word;
        end
      end
      default: bubble = 1'b1;
    endcase
  end

  // IF/ID register: flush beats everything, otherwise capture or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr    <= NOP;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
    end else if (flush) begin
      if_id_instr <= NOP;
      if_id_valid <= 1'b0;
    end else if (capture) begin
      if_id_instr    <= capture_word;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
    end else if (bubble) begin
      if_id_instr <= NOP;
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;

  int vectors;
  int miscompares;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_src         (pc_src),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .jr_target      (jr_target),
    .stall          (stall),
    .flush          (flush),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a word tagged with the low half of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] p4);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, "_instr"}, if_id_instr, ins);
    chk({tag, "_pc4"}, if_id_pc_plus4, p4);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    pc_src        = 2'b00;
    branch_target = 32'h0;
    jump_target   = 32'h0;
    jr_target     = 32'h0;
    stall         = 1'b0;
    flush         = 1'b0;
    imem_ready    = 1'b1;

    // Reset state
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk_ifid("rst", 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);

    // Zero-wait sequential fetch
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_addr, 32'(i * 4));
      tick();
      chk_ifid("seq", 1'b1, mem_word(32'(i * 4)), 32'(i * 4 + 4));
    end
    chk("seq_end_addr", imem_addr, 32'h10);

    // Wait states at 0x10
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr", imem_addr, 32'h10);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk_ifid("wait", 1'b0, 32'h0, 32'h10);
    end
    imem_ready = 1'b1;
    tick();
    chk_ifid("wait_cap", 1'b1, 32'hC0DE_0010, 32'h14);
    chk("wait_next_addr", imem_addr, 32'h14);

    // Branch while waiting -> DRAIN, old data dropped, refetch at 0x40
    imem_ready    = 1'b0;
    pc_src        = 2'b01;
    branch_target = 32'h43;
    tick();
    chk("drain_addr_held", imem_addr, 32'h14);
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    chk("drain_bubble", {31'd0, if_id_valid}, 32'd0);
    pc_src     = 2'b00;
    imem_ready = 1'b1;
    tick();
    chk("drain_discard_valid", {31'd0, if_id_valid}, 32'd0);
    chk("drain_discard_instr", if_id_instr, 32'h0);
    chk("drain_new_addr", imem_addr, 32'h40);
    tick();
    chk_ifid("br_cap", 1'b1, 32'hC0DE_0040, 32'h44);

    // Stall coincident with a transfer -> HELD
    stall = 1'b1;
    tick();
    chk("held_req", {31'd0, imem_req}, 32'd0);
    chk_ifid("held_frozen", 1'b1, 32'hC0DE_0040, 32'h44);
    tick();
    chk("held_req2", {31'd0, imem_req}, 32'd0);
    chk_ifid("held_frozen2", 1'b1, 32'hC0DE_0040, 32'h44);
    stall = 1'b0;
    tick();
    chk_ifid("held_release", 1'b1, 32'hC0DE_0044, 32'h48);
    chk("held_release_addr", imem_addr, 32'h48);
    chk("held_release_req", {31'd0, imem_req}, 32'd1);

    // Flush together with stall
    stall = 1'b1;
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
    chk("flush_instr", if_id_instr, 32'h0);
    stall = 1'b0;
    flush = 1'b0;
    tick();
    chk_ifid("flush_after", 1'b1, 32'hC0DE_0048, 32'h4C);

    // Jump to the top word (low bits masked), then wrap
    pc_src      = 2'b10;
    jump_target = 32'hFFFF_FFFF;
    tick();
    chk("jump_addr", imem_addr, 32'hFFFF_FFFC);
    chk("jump_bubble", {31'd0, if_id_valid}, 32'd0);
    pc_src = 2'b00;
    tick();
    chk_ifid("wrap", 1'b1, 32'hC0DE_FFFC, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Jump-register with transfer
    pc_src    = 2'b11;
    jr_target = 32'h0000_0102;
    tick();
    chk("jr_addr", imem_addr, 32'h100);
    pc_src = 2'b00;

    // Reset pulse mid-wait
    imem_ready = 1'b0;
    tick();
    chk("pre_rst_addr", imem_addr, 32'h100);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_valid", {31'd0, if_id_valid}, 32'd0);
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    #1;
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk_ifid("restart", 1'b1, 32'hC0DE_0000, 32'h4);
    chk("restart_next_addr", imem_addr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
